ctrl_ajuste_relogio: RTL and testbench
======================================

# ctrl_ajuste_relogio

Time-base and set-mode controller for the clock datapath (seconds → minutes → hours BCD counter chain). Generates the one-second advance strobe for the seconds counter. Runs a button-driven FSM that lets the user select hours or minutes and step them. Drives display blink and carry-inhibit controls while in set mode.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: `main_clock` cycles per second. Must be even and ≥ 4.

Ports:
- `main_clock` in 1: sole clock, rising edge.
- `main_reset` in 1: synchronous, active-high reset.
- `btn_mode` in 1: mode button, level, already synchronized and debounced, active-high.
- `btn_inc` in 1: increment button, same conditioning as `btn_mode`.
- `tick_s` out 1: one-cycle advance pulse to the seconds counter.
- `inc_m` out 1: one-cycle step pulse to the minutes counter.
- `inc_h` out 1: one-cycle step pulse to the hours counter.
- `sec_clear` out 1: level; seconds counter holds 00 while high.
- `carry_block` out 1: level; minute wrap must not advance hours while high.
- `blank_m` out 1: level; blank minute digits (blink).
- `blank_h` out 1: level; blank hour digits (blink).
- `mode` out 2: current FSM state encoding.

## Operation
- Reset values: FSM = RUN, prescaler = 0, all 1-bit outputs 0, `mode` = 0.
- FSM states and encodings: RUN = 0, SET_H = 1, SET_M = 2. Encoding 3 is illegal and recovers to RUN on the next edge.
- Transitions occur on a `btn_mode` rising edge only: RUN → SET_H → SET_M → RUN.
- Rising edge definition: input high this cycle, registered previous value low. Held levels never retrigger.
- Prescaler `cnt`:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Cleared to 0 on every state change.
  - In RUN, each wrap emits `tick_s`.
  - In SET states, `tick_s` = 0.
- `btn_inc` rising edge:
  - In SET_H: one `inc_h` pulse.
  - In SET_M: one `inc_m` pulse.
  - In RUN: ignored.
- `sec_clear` = `carry_block` = 1 in SET_H and SET_M; 0 in RUN.
- Blink:
  - `blank_h` = 1 iff state is SET_H and `cnt` ≥ TICK_DIV/2.
  - `blank_m` is the same for SET_M.
  - Both are 0 in RUN.
- Simultaneous `btn_mode` and `btn_inc` edges: mode wins, the inc edge is discarded. No pulse is emitted for the old or the new field.
- Reset mid-set: returns to RUN on the reset edge. Any pending pulse is dropped. Button history registers load the current input levels, so a button held through reset does not produce an edge afterwards.

## Timing
- All outputs are registered.
- Button response: edge sampled at clock edge N → state/pulse visible in cycle N+1. Latency is 1 cycle.
- `tick_s`: high for exactly 1 cycle, every TICK_DIV cycles in RUN.
  - The first tick after reset or after returning to RUN is visible in cycle TICK_DIV after the clearing edge.
- `inc_m` / `inc_h`: exactly 1 cycle wide. Never asserted in the same cycle as `tick_s`, and never asserted together.
- Blink phase is derived from the same `cnt`, so period = TICK_DIV cycles at 50% duty. It starts unblanked after each state entry.

## Configuration
- Macro: `CTRL_AJUSTE_AUTOREP_EN`.
- Defined: auto-repeat is enabled in the SET states.
  - While `btn_inc` is held continuously, a hold counter (cleared on release or state change) emits one extra step pulse after TICK_DIV cycles of hold.
  - After that, one step pulse every TICK_DIV/2 cycles until release.
  - Pulse type follows the current state.
- Undefined: exactly one step pulse per press, and no hold counter is instantiated.

## Structure
- Package `relogio_pkg`:
  - `typedef enum logic [1:0] {RUN, SET_H, SET_M} mode_t`.
  - Localparam helper for counter width: `$clog2(TICK_DIV)`.
- Sub-module `borda_botao`: registered rising-edge detector with synchronous reset-to-input-level. Instantiated once per button.
- Prescaler, FSM, pulse/blink logic and the optional auto-repeat counter live in the top module.

## Test plan
All scenarios use TICK_DIV = 10.
- Reset then idle 35 cycles → `tick_s` pulses in cycles 10, 20, 30 only. `mode` = 0; `sec_clear`, `carry_block`, `blank_*` stay 0.
- `btn_mode` pulse once → `mode` = 1 next cycle. `sec_clear` = `carry_block` = 1, `tick_s` stays 0, and `blank_h` toggles with 5-cycle phases starting low.
- In SET_H, three separate `btn_inc` presses → exactly three 1-cycle `inc_h` pulses and no `inc_m`. Then `btn_mode` ×2 → `mode` back to 0, and the first `tick_s` arrives 10 cycles later.
- `btn_mode` and `btn_inc` rise in the same cycle while in SET_H → `mode` = 2 and no `inc_h` or `inc_m` pulse.
- Assert `main_reset` for 1 cycle while in SET_M with `btn_inc` held → next cycle `mode` = 0 and all outputs 0. No `inc_*` pulse after release/re-press in RUN.
- With `CTRL_AJUSTE_AUTOREP_EN`, hold `btn_inc` for 30 cycles in SET_M → `inc_m` pulses at press+1, +11, +16, +21, +26. Without the macro, a single pulse only.

Source files
------------

// File: rtl/ctrl_ajuste_relogio_pkg.sv
// Shared types and helpers for the clock set-mode controller.
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } mode_t;

  localparam int unsigned TICK_DIV_DEF = 50_000_000;

  // Width of a counter spanning 0..div-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ctrl_ajuste_relogio_borda_botao.sv
// Rising-edge detector for a conditioned button; reset loads the current level
// so a button held through reset never reports an edge afterwards.
module borda_botao (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= btn_i;
    else       prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/ctrl_ajuste_relogio.sv
// Time base and set-mode FSM for the BCD clock chain.
// Optional auto-repeat of the step button: define CTRL_AJUSTE_AUTOREP_EN.
module ctrl_ajuste_relogio
  import relogio_pkg::*;
#(
  parameter int unsigned TICK_DIV = relogio_pkg::TICK_DIV_DEF
) (
  input  logic       main_clock,
  input  logic       main_reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       tick_s,
  output logic       inc_m,
  output logic       inc_h,
  output logic       sec_clear,
  output logic       carry_block,
  output logic       blank_m,
  output logic       blank_h,
  output logic [1:0] mode
);

  localparam int unsigned CW = cnt_w(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

  mode_t         state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          inc_m_q, inc_m_d;
  logic          inc_h_q, inc_h_d;
  logic          set_q, set_d;
  logic          blank_m_q, blank_m_d;
  logic          blank_h_q, blank_h_d;
  logic          mode_rise, inc_rise;
  logic          chg, step, rep_fire;

  borda_botao u_borda_mode (
    .clk_i (main_clock),
    .rst_i (main_reset),
    .btn_i (btn_mode),
    .rise_o(mode_rise)
  );

  borda_botao u_borda_inc (
    .clk_i (main_clock),
    .rst_i (main_reset),
    .btn_i (btn_inc),
    .rise_o(inc_rise)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mode_rise) state_d = SET_H;
      SET_H:   if (mode_rise) state_d = SET_M;
      SET_M:   if (mode_rise) state_d = RUN;
      default: state_d = RUN;
    endcase
    chg = (state_d != state_q);

    cnt_d = (chg || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    // A mode edge in the same cycle swallows the step edge entirely.
    step      = ~chg & (inc_rise | rep_fire);
    tick_d    = ~chg & (state_q == RUN) & (cnt_q == CNT_LAST);
    inc_h_d   = step & (state_q == SET_H);
    inc_m_d   = step & (state_q == SET_M);
    set_d     = (state_d != RUN);
    blank_h_d = (state_d == SET_H) & (cnt_d >= CNT_HALF);
    blank_m_d = (state_d == SET_M) & (cnt_d >= CNT_HALF);
  end

`ifdef CTRL_AJUSTE_AUTOREP_EN
  localparam int unsigned HW = cnt_w(TICK_DIV + 1);
  localparam logic [HW-1:0] HOLD_FULL   = HW'(TICK_DIV);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(TICK_DIV / 2 + 1);

  logic [HW-1:0] hold_q, hold_d;

  // Reloading to half way makes every later repeat TICK_DIV/2 cycles apart.
  always_comb begin
    rep_fire = 1'b0;
    hold_d   = '0;
    if (btn_inc && !chg && state_q != RUN) begin
      if (hold_q == HOLD_FULL) begin
        rep_fire = 1'b1;
        hold_d   = HOLD_RELOAD;
      end else begin
        hold_d   = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge main_clock) begin
    if (main_reset) hold_q <= '0;
    else            hold_q <= hold_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge main_clock) begin
    if (main_reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      inc_m_q   <= 1'b0;
      inc_h_q   <= 1'b0;
      set_q     <= 1'b0;
      blank_m_q <= 1'b0;
      blank_h_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      inc_m_q   <= inc_m_d;
      inc_h_q   <= inc_h_d;
      set_q     <= set_d;
      blank_m_q <= blank_m_d;
      blank_h_q <= blank_h_d;
    end
  end

  assign tick_s      = tick_q;
  assign inc_m       = inc_m_q;
  assign inc_h       = inc_h_q;
  assign sec_clear   = set_q;
  assign carry_block = set_q;
  assign blank_m     = blank_m_q;
  assign blank_h     = blank_h_q;
  assign mode        = state_q;

endmodule

// File: tb/tb_ctrl_ajuste_relogio.sv
// Directed bench for ctrl_ajuste_relogio with TICK_DIV = 10.
module tb_ctrl_ajuste_relogio;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bmode = 1'b0;
  logic       binc = 1'b0;
  logic       tick_s, inc_m, inc_h, sec_clear, carry_block, blank_m, blank_h;
  logic [1:0] mode;
  logic [8:0] obs;
  logic [8:0] exp_v;
  int         n_chk = 0;
  int         n_fail = 0;

  ctrl_ajuste_relogio #(.TICK_DIV(10)) dut (
    .main_clock (clk),
    .main_reset (rst),
    .btn_mode   (bmode),
    .btn_inc    (binc),
    .tick_s     (tick_s),
    .inc_m      (inc_m),
    .inc_h      (inc_h),
    .sec_clear  (sec_clear),
    .carry_block(carry_block),
    .blank_m    (blank_m),
    .blank_h    (blank_h),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  assign obs = {tick_s, inc_m, inc_h, sec_clear, carry_block, blank_m, blank_h, mode};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bmode = 1'b0; binc = 1'b0;
    step();
    rst = 1'b0;
    n_chk++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 9'b0);
    end
    for (int c = 1; c <= 35; c++) begin
      step();
      exp_v = {(c % 10 == 0), 8'b0};
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL run_tick cycle %0d: got %b expected %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_set_h_blink();
    bmode = 1'b1;
    step();
    bmode = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      exp_v = {3'b000, 2'b11, 1'b0, ((k % 10) >= 5), 2'd1};
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL set_h_blink k=%0d: got %b expected %b", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_inc_h();
    for (int p = 0; p < 3; p++) begin
      binc = 1'b1;
      step();
      n_chk++;
      if ({inc_h, inc_m, tick_s} !== 3'b100) begin
        n_fail++;
        $display("FAIL inc_h_press %0d: got %b expected %b", p, {inc_h, inc_m, tick_s}, 3'b100);
      end
      step();
      n_chk++;
      if ({inc_h, inc_m} !== 2'b00) begin
        n_fail++;
        $display("FAIL inc_h_held %0d: got %b expected %b", p, {inc_h, inc_m}, 2'b00);
      end
      binc = 1'b0;
      step();
      n_chk++;
      if ({inc_h, inc_m} !== 2'b00) begin
        n_fail++;
        $display("FAIL inc_h_released %0d: got %b expected %b", p, {inc_h, inc_m}, 2'b00);
      end
    end
    bmode = 1'b1;
    step();
    bmode = 1'b0;
    n_chk++;
    if (mode !== 2'd2) begin
      n_fail++;
      $display("FAIL to_set_m: got %0d expected %0d", mode, 2);
    end
    step();
    bmode = 1'b1;
    step();
    bmode = 1'b0;
    n_chk++;
    if ({mode, sec_clear, carry_block} !== 4'b0000) begin
      n_fail++;
      $display("FAIL back_to_run: got %b expected %b", {mode, sec_clear, carry_block}, 4'b0000);
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      n_chk++;
      if (tick_s !== (k == 10)) begin
        n_fail++;
        $display("FAIL first_tick k=%0d: got %b expected %b", k, tick_s, (k == 10));
      end
    end
  endtask

  task automatic test_simultaneous();
    bmode = 1'b1;
    step();
    bmode = 1'b0;
    step();
    n_chk++;
    if (mode !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_enter_set_h: got %0d expected %0d", mode, 1);
    end
    bmode = 1'b1; binc = 1'b1;
    step();
    bmode = 1'b0; binc = 1'b0;
    n_chk++;
    if ({mode, inc_h, inc_m} !== 4'b1000) begin
      n_fail++;
      $display("FAIL simul_edge: got %b expected %b", {mode, inc_h, inc_m}, 4'b1000);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++;
      if ({mode, inc_h, inc_m} !== 4'b1000) begin
        n_fail++;
        $display("FAIL simul_after k=%0d: got %b expected %b", k, {mode, inc_h, inc_m}, 4'b1000);
      end
    end
  endtask

  task automatic test_reset_mid_set();
    binc = 1'b1;
    step();
    n_chk++;
    if ({mode, inc_m, inc_h} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mid_set_press: got %b expected %b", {mode, inc_m, inc_h}, 4'b1010);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (obs !== 9'b0) begin
      n_fail++;
      $display("FAIL mid_set_reset: got %b expected %b", obs, 9'b0);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) binc = 1'b0;
      if (k == 2) binc = 1'b1;
      step();
      n_chk++;
      if (obs !== 9'b0) begin
        n_fail++;
        $display("FAIL after_reset k=%0d: got %b expected %b", k, obs, 9'b0);
      end
    end
    binc = 1'b0;
    step();
  endtask

  task automatic test_autorepeat();
    logic want;
    for (int m = 0; m < 2; m++) begin
      bmode = 1'b1;
      step();
      bmode = 1'b0;
      step();
    end
    n_chk++;
    if (mode !== 2'd2) begin
      n_fail++;
      $display("FAIL autorep_enter: got %0d expected %0d", mode, 2);
    end
    binc = 1'b1;
    for (int k = 0; k < 33; k++) begin
      step();
      if (k == 29) binc = 1'b0;
`ifdef CTRL_AJUSTE_AUTOREP_EN
      want = (k == 0) || (k == 10) || (k == 15) || (k == 20) || (k == 25);
`else
      want = (k == 0);
`endif
      n_chk++;
      if ({inc_m, inc_h} !== {want, 1'b0}) begin
        n_fail++;
        $display("FAIL autorep k=%0d: got %b expected %b", k, {inc_m, inc_h}, {want, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_h_blink();
    test_inc_h();
    test_simultaneous();
    test_reset_mid_set();
    test_autorepeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
